// File: rtl/zustands_pruefer_if.sv
// Bus between the schaltung state machine (or a bench driving its role) and the
// zustands_pruefer monitor.
//   a,b,c    : sampled state bits, a is MSB
//   d,e,f    : sampled output bits, expected to mirror a,b,c
//   locked   : monitor is locked onto the mod-8 count
//   err      : one-cycle pulse per error detected while locked
//   mirr_err : last sample had {d,e,f} != {a,b,c}
//   wrap     : one-cycle pulse on a correct 7->0 step while locked
//   err_cnt  : saturating count of err pulses
interface zustands_pruefer_if #(
  parameter int unsigned ERR_W = 8
);
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             e;
  logic             f;
  logic             locked;
  logic             err;
  logic             mirr_err;
  logic             wrap;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output a, b, c, d, e, f,
    input  locked, err, mirr_err, wrap, err_cnt
  );

  modport slave (
    input  a, b, c, d, e, f,
    output locked, err, mirr_err, wrap, err_cnt
  );
endinterface

// File: rtl/zustands_pruefer.sv
// Receive-side checker for the 3-bit free-running counter schaltung.
// Samples the state bits and their mirrored output bits every clock, locks onto
// the ascending mod-8 sequence after LOCK_LEN consecutive correct increments,
// and then reports skipped/stalled/backwards states and mirror mismatches.
//   clk : system clock, rising edge
//   rst : synchronous reset, active-high
//   bus : slave side of zustands_pruefer_if (inputs a..f, registered status outputs)
module zustands_pruefer #(
  parameter int unsigned LOCK_LEN = 3,
  parameter int unsigned ERR_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  zustands_pruefer_if.slave  bus
);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t           state;
  logic [2:0]       prev;
  logic             prev_vld;
  logic [2:0]       run;
  logic             locked_q;
  logic             err_q;
  logic             mirr_q;
  logic             wrap_q;
  logic [ERR_W-1:0] cnt_q;

  logic [2:0]       v;
  logic [2:0]       w;
  logic             good;
  logic             mirr_now;

  assign v = {bus.a, bus.b, bus.c};
  assign w = {bus.d, bus.e, bus.f};

  // Written as if/else so that X on the inputs falls into the "not good" /
  // "mismatch" branch instead of propagating X into the state.
  always_comb begin
    good = 1'b0;
    if (prev_vld && (v == prev + 3'd1) && (w == v)) good = 1'b1;
    mirr_now = 1'b1;
    if (w == v) mirr_now = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      prev     <= '0;
      prev_vld <= 1'b0;
      run      <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      mirr_q   <= 1'b0;
      wrap_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // Every sample becomes the reference for the next one, including an
      // erroneous one, so a fresh run can start from it.
      prev     <= v;
      prev_vld <= 1'b1;
      mirr_q   <= mirr_now;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
      case (state)
        HUNT: begin
          if (good) begin
            if (run + 3'd1 == 3'(LOCK_LEN)) begin
              state    <= LOCKED;
              locked_q <= 1'b1;
              run      <= '0;
            end else begin
              run <= run + 3'd1;
            end
          end else begin
            run <= '0;
          end
        end
        LOCKED: begin
          if (good) begin
            wrap_q <= (prev == 3'd7);
          end else begin
            // A mirror mismatch and a sequence error on the same sample still
            // count as a single error.
            err_q    <= 1'b1;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            state    <= HUNT;
            locked_q <= 1'b0;
            run      <= '0;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  assign bus.locked   = locked_q;
  assign bus.err      = err_q;
  assign bus.mirr_err = mirr_q;
  assign bus.wrap     = wrap_q;
  assign bus.err_cnt  = cnt_q;

endmodule

// File: tb/tb_zustands_pruefer.sv
module tb_zustands_pruefer;

  localparam int unsigned LOCK_LEN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] va  = '0;
  logic [2:0] vw  = '0;

  always #5 clk = ~clk;

  zustands_pruefer_if #(.ERR_W(8)) bus8 ();
  zustands_pruefer_if #(.ERR_W(2)) bus2 ();

  assign {bus8.a, bus8.b, bus8.c} = va;
  assign {bus8.d, bus8.e, bus8.f} = vw;
  assign {bus2.a, bus2.b, bus2.c} = va;
  assign {bus2.d, bus2.e, bus2.f} = vw;

  zustands_pruefer #(.LOCK_LEN(LOCK_LEN), .ERR_W(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  zustands_pruefer #(.LOCK_LEN(LOCK_LEN), .ERR_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  typedef struct packed {
    logic       locked;
    logic       err;
    logic       mirr;
    logic       wrap;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state
  logic [2:0] m_prev   = '0;
  logic       m_vld    = 1'b0;
  int         m_run    = 0;
  logic       m_locked = 1'b0;
  logic       m_err    = 1'b0;
  logic       m_mirr   = 1'b0;
  logic       m_wrap   = 1'b0;
  logic [7:0] m_cnt8   = '0;
  logic [1:0] m_cnt2   = '0;

  task automatic model(input logic r, input logic [2:0] v, input logic [2:0] w);
    logic [2:0] nxt;
    logic       g;
    if (r) begin
      m_prev = '0; m_vld = 1'b0; m_run = 0; m_locked = 1'b0;
      m_err = 1'b0; m_mirr = 1'b0; m_wrap = 1'b0; m_cnt8 = '0; m_cnt2 = '0;
    end else begin
      nxt    = m_prev + 3'd1;
      g      = m_vld && (v == nxt) && (w == v);
      m_err  = 1'b0;
      m_wrap = 1'b0;
      m_mirr = (w != v);
      if (!m_locked) begin
        if (g) begin
          if (m_run + 1 == LOCK_LEN) begin
            m_locked = 1'b1;
            m_run    = 0;
          end else begin
            m_run = m_run + 1;
          end
        end else begin
          m_run = 0;
        end
      end else if (g) begin
        m_wrap = (m_prev == 3'd7);
      end else begin
        m_err    = 1'b1;
        m_locked = 1'b0;
        m_run    = 0;
        if (m_cnt8 != 8'hff) m_cnt8 = m_cnt8 + 8'd1;
        if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
      end
      m_prev = v;
      m_vld  = 1'b1;
    end
  endtask

  // Drive one sample, push its expected outputs, and return after the
  // scoreboard monitor has compared them.
  task automatic step(input logic r, input logic [2:0] v, input logic [2:0] w);
    exp_t x;
    @(negedge clk);
    rst = r;
    va  = v;
    vw  = w;
    model(r, v, w);
    x = '{locked: m_locked, err: m_err, mirr: m_mirr, wrap: m_wrap,
          cnt8: m_cnt8, cnt2: m_cnt2};
    sb.push_back(x);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      total++;
      if ({bus8.locked, bus8.err, bus8.mirr_err, bus8.wrap, bus8.err_cnt} !==
          {x.locked, x.err, x.mirr, x.wrap, x.cnt8}) begin
        bad++;
        $display("FAIL sb_dut8 @%0t: got l/e/m/w/cnt=%b%b%b%b/%0d want %b%b%b%b/%0d",
                 $time, bus8.locked, bus8.err, bus8.mirr_err, bus8.wrap, bus8.err_cnt,
                 x.locked, x.err, x.mirr, x.wrap, x.cnt8);
      end
      total++;
      if ({bus2.locked, bus2.err, bus2.mirr_err, bus2.wrap, bus2.err_cnt} !==
          {x.locked, x.err, x.mirr, x.wrap, x.cnt2}) begin
        bad++;
        $display("FAIL sb_dut2 @%0t: got l/e/m/w/cnt=%b%b%b%b/%0d want %b%b%b%b/%0d",
                 $time, bus2.locked, bus2.err, bus2.mirr_err, bus2.wrap, bus2.err_cnt,
                 x.locked, x.err, x.mirr, x.wrap, x.cnt2);
      end
    end
  end

  task automatic lock_from_zero();
    for (int i = 0; i < 4; i++) step(1'b0, 3'(i), 3'(i));
  endtask

  task automatic test_reset();
    step(1'b1, 3'd5, 3'd2);
    step(1'b1, 3'd5, 3'd2);
    total++;
    if ({bus8.locked, bus8.err, bus8.mirr_err, bus8.wrap, bus8.err_cnt} !== 12'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b%b%b%b cnt=%0d want 0000 cnt=0",
               bus8.locked, bus8.err, bus8.mirr_err, bus8.wrap, bus8.err_cnt);
    end
  endtask

  task automatic test_count();
    int wraps;
    wraps = 0;
    step(1'b1, 3'd0, 3'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 3'(i), 3'(i));
      total++;
      if (bus8.locked !== (i >= 3)) begin
        bad++;
        $display("FAIL count_locked[%0d]: got %b want %b", i, bus8.locked, (i >= 3));
      end
      if (bus8.wrap === 1'b1) wraps++;
      if (i == 8) begin
        total++;
        if (bus8.wrap !== 1'b1) begin
          bad++;
          $display("FAIL count_wrap_at_0: got %b want 1", bus8.wrap);
        end
      end
    end
    total++;
    if (wraps != 1) begin
      bad++;
      $display("FAIL count_wrap_total: got %0d want 1", wraps);
    end
    total++;
    if (bus8.err_cnt !== 8'd0) begin
      bad++;
      $display("FAIL count_err_cnt: got %0d want 0", bus8.err_cnt);
    end
  endtask

  task automatic test_skip();
    step(1'b1, 3'd0, 3'd0);
    lock_from_zero();
    step(1'b0, 3'd5, 3'd5);
    total++;
    if ({bus8.err, bus8.locked, bus8.err_cnt} !== {1'b1, 1'b0, 8'd1}) begin
      bad++;
      $display("FAIL skip_err: got err=%b locked=%b cnt=%0d want err=1 locked=0 cnt=1",
               bus8.err, bus8.locked, bus8.err_cnt);
    end
    step(1'b0, 3'd6, 3'd6);
    total++;
    if (bus8.err !== 1'b0) begin
      bad++;
      $display("FAIL skip_err_pulse: got %b want 0", bus8.err);
    end
    step(1'b0, 3'd7, 3'd7);
    total++;
    if (bus8.locked !== 1'b0) begin
      bad++;
      $display("FAIL skip_early_lock: got %b want 0", bus8.locked);
    end
    step(1'b0, 3'd0, 3'd0);
    total++;
    if ({bus8.locked, bus8.wrap} !== 2'b10) begin
      bad++;
      $display("FAIL skip_relock: got locked=%b wrap=%b want locked=1 wrap=0",
               bus8.locked, bus8.wrap);
    end
  endtask

  task automatic test_mirror_locked();
    step(1'b1, 3'd0, 3'd0);
    lock_from_zero();
    step(1'b0, 3'd4, 3'd4);
    step(1'b0, 3'd5, 3'd0);
    total++;
    if ({bus8.mirr_err, bus8.err, bus8.locked, bus8.err_cnt} !== {1'b1, 1'b1, 1'b0, 8'd1}) begin
      bad++;
      $display("FAIL mirror_locked: got mirr=%b err=%b locked=%b cnt=%0d want 1 1 0 1",
               bus8.mirr_err, bus8.err, bus8.locked, bus8.err_cnt);
    end
  endtask

  task automatic test_mirror_hunt();
    step(1'b1, 3'd0, 3'd0);
    step(1'b0, 3'd2, 3'd7);
    total++;
    if ({bus8.mirr_err, bus8.err, bus8.err_cnt} !== {1'b1, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL mirror_hunt: got mirr=%b err=%b cnt=%0d want 1 0 0",
               bus8.mirr_err, bus8.err, bus8.err_cnt);
    end
  endtask

  task automatic test_saturate();
    logic [2:0] cur;
    logic [1:0] want;
    step(1'b1, 3'd0, 3'd0);
    lock_from_zero();
    cur = 3'd3;
    for (int k = 0; k < 5; k++) begin
      cur = cur + 3'd2;
      step(1'b0, cur, cur);
      want = (k < 3) ? 2'(k + 1) : 2'd3;
      total++;
      if (bus2.err_cnt !== want) begin
        bad++;
        $display("FAIL sat_cnt2[%0d]: got %0d want %0d", k, bus2.err_cnt, want);
      end
      total++;
      if (bus8.err_cnt !== 8'(k + 1)) begin
        bad++;
        $display("FAIL sat_cnt8[%0d]: got %0d want %0d", k, bus8.err_cnt, k + 1);
      end
      for (int j = 0; j < 3; j++) begin
        cur = cur + 3'd1;
        step(1'b0, cur, cur);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 3'd0, 3'd0);
    lock_from_zero();
    step(1'b0, 3'd4, 3'd4);
    step(1'b0, 3'd5, 3'd5);
    step(1'b1, 3'd6, 3'd6);
    total++;
    if ({bus8.locked, bus8.err, bus8.mirr_err, bus8.wrap, bus8.err_cnt} !== 12'd0) begin
      bad++;
      $display("FAIL midreset_outputs: got %b%b%b%b cnt=%0d want 0000 cnt=0",
               bus8.locked, bus8.err, bus8.mirr_err, bus8.wrap, bus8.err_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 3'(6 + i), 3'(6 + i));
      total++;
      if (bus8.locked !== (i == 3)) begin
        bad++;
        $display("FAIL midreset_relock[%0d]: got %b want %b", i, bus8.locked, (i == 3));
      end
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 3'd0, 3'd0);
    lock_from_zero();
    step(1'b0, 3'd3, 3'd3);
    total++;
    if ({bus8.err, bus8.err_cnt} !== {1'b1, 8'd1}) begin
      bad++;
      $display("FAIL stall_err: got err=%b cnt=%0d want 1 1", bus8.err, bus8.err_cnt);
    end
    step(1'b0, 3'd4, 3'd4);
    step(1'b0, 3'd5, 3'd5);
    step(1'b0, 3'd6, 3'd6);
    step(1'b0, 3'd5, 3'd5);
    total++;
    if ({bus8.err, bus8.locked, bus8.err_cnt} !== {1'b1, 1'b0, 8'd2}) begin
      bad++;
      $display("FAIL backwards_err: got err=%b locked=%b cnt=%0d want 1 0 2",
               bus8.err, bus8.locked, bus8.err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_skip();
    test_mirror_locked();
    test_mirror_hunt();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
    @(posedge clk);
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
